// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter over N valid/ready input streams.
// Winner's payload and one-hot grant are registered into one output slot.
module rr_stream_arbiter #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_valid,
  output logic [N-1:0]    i_ready,
  input  logic [N*DW-1:0] i_data,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [DW-1:0]   o_data,
  output logic [N-1:0]    o_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] pick_idx, nxt_ptr;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d, pick_data;
  logic [N-1:0]  grant_q, grant_d, pick;
  logic          load, found;

  // Priority slot k maps to input (ptr + k) mod N, never mod 2^PW.
  function automatic int wrap_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return s;
  endfunction

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && j == wrap_idx(ptr_q, k) && i_valid[j]) begin
          pick[j]  = 1'b1;
          pick_idx = PW'(j);
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int j = 0; j < N; j++) begin
      if (pick[j]) pick_data = pick_data | i_data[j*DW +: DW];
    end
  end

  assign nxt_ptr = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;
  assign load    = ~valid_q | o_ready;
  assign i_ready = (load && !rst) ? pick : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = found;
      grant_d = pick;
      if (found) begin
        data_d = pick_data;
        ptr_d  = nxt_ptr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_grant = grant_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Scoreboard bench for rr_stream_arbiter: N=4 and N=3 instances.
// Expected grant/data words are queued at stimulus time and popped per load.
module tb_rr_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v4, r4, og4;
  logic [31:0] d4;
  logic        ov4, or4;
  logic [7:0]  od4;
  logic [2:0]  v3, r3, og3;
  logic [23:0] d3;
  logic        ov3, or3;
  logic [7:0]  od3;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_g[$];
  logic [7:0] exp_d[$];
  logic [3:0] eg;
  logic [7:0] ed;

  always #5 clk = ~clk;

  rr_stream_arbiter #(.DW(8), .N(4)) dut4 (
    .clk(clk), .rst(rst),
    .i_valid(v4), .i_ready(r4), .i_data(d4),
    .o_valid(ov4), .o_ready(or4), .o_data(od4), .o_grant(og4)
  );

  rr_stream_arbiter #(.DW(8), .N(3)) dut3 (
    .clk(clk), .rst(rst),
    .i_valid(v3), .i_ready(r3), .i_data(d3),
    .o_valid(ov3), .o_ready(or3), .o_data(od3), .o_grant(og3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_g.delete();
    exp_d.delete();
    v4 = '0; v3 = '0; or4 = 1'b0; or3 = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pop_check4(input string nm);
    eg = exp_g.pop_front();
    ed = exp_d.pop_front();
    total++;
    if (ov4 !== 1'b1 || og4 !== eg || od4 !== ed) begin
      bad++;
      $display("FAIL %s: got v=%b g=%b d=%h, want v=1 g=%b d=%h",
               nm, ov4, og4, od4, eg, ed);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; v4 = 4'hF; v3 = 3'h7; or4 = 1'b0; or3 = 1'b0;
    #3;
    total++;
    if (r4 !== 4'b0000 || r3 !== 3'b000) begin
      bad++;
      $display("FAIL rst_ready: got r4=%b r3=%b, want 0", r4, r3);
    end
    step();
    v4 = '0; v3 = '0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (ov4 !== 1'b0 || og4 !== 4'b0 || od4 !== 8'h00 || r4 !== 4'b0) begin
        bad++;
        $display("FAIL idle%0d: got v=%b g=%b d=%h r=%b, want all 0",
                 i, ov4, og4, od4, r4);
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    or4 = 1'b1;
    v4  = 4'hF;
    #1;
    total++;
    if (r4 !== 4'b0001) begin
      bad++;
      $display("FAIL cont_ready0: got %b want 0001", r4);
    end
    for (int i = 0; i < 8; i++) begin
      exp_g.push_back(4'(1 << (i % 4)));
      exp_d.push_back(8'(8'hA0 + i % 4));
    end
    for (int i = 0; i < 8; i++) begin
      step();
      pop_check4("contention");
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    v4 = 4'hF;
    exp_g.push_back(4'b0001); exp_d.push_back(8'hA0);
    exp_g.push_back(4'b0010); exp_d.push_back(8'hA1);
    step();
    pop_check4("bp_first");
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (og4 !== eg || od4 !== ed || ov4 !== 1'b1 || r4 !== 4'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b g=%b d=%h r=%b, want 1 %b %h 0000",
                 i, ov4, og4, od4, r4, eg, ed);
      end
    end
    or4 = 1'b1;
    #1;
    total++;
    if (r4 !== 4'b0010) begin
      bad++;
      $display("FAIL bp_ptr: got r=%b want 0010", r4);
    end
    step();
    pop_check4("bp_resume");
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    or3 = 1'b1;
    v3  = 3'b101;
    #1;
    total++;
    if (r3 !== 3'b001) begin
      bad++;
      $display("FAIL wrap_ready0: got %b want 001", r3);
    end
    for (int i = 0; i < 4; i++) begin
      exp_g.push_back((i % 2 == 0) ? 4'b0001 : 4'b0100);
      exp_d.push_back((i % 2 == 0) ? 8'hC0 : 8'hC2);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      eg = exp_g.pop_front();
      ed = exp_d.pop_front();
      total++;
      if (ov3 !== 1'b1 || {1'b0, og3} !== eg || od3 !== ed) begin
        bad++;
        $display("FAIL wrap%0d: got v=%b g=%b d=%h, want 1 %b %h",
                 i, ov3, og3, od3, eg[2:0], ed);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    or4 = 1'b1;
    v4  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      exp_g.push_back(4'(1 << i));
      exp_d.push_back(8'(8'hA0 + i));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      pop_check4("ar_pre");
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ov4 !== 1'b0 || og4 !== 4'b0 || r4 !== 4'b0) begin
      bad++;
      $display("FAIL ar_now: got v=%b g=%b r=%b, want 0 0000 0000",
               ov4, og4, r4);
    end
    v4 = 4'b1100;
    #2;
    rst = 1'b0;
    exp_g.push_back(4'b0100); exp_d.push_back(8'hA2);
    step();
    pop_check4("ar_first");
  endtask

  task automatic test_late_arrival();
    logic [3:0] seen;
    logic       got3;
    logic       dup;
    do_reset();
    or4 = 1'b1;
    v4  = 4'b0111;
    exp_g.push_back(4'b0001); exp_d.push_back(8'hA0);
    exp_g.push_back(4'b0010); exp_d.push_back(8'hA1);
    step();
    pop_check4("late_pre0");
    step();
    pop_check4("late_pre1");
    v4   = 4'hF;
    seen = '0;
    got3 = 1'b0;
    dup  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!got3) begin
        if ((seen & og4) != 4'b0) dup = 1'b1;
        seen = seen | og4;
        if (og4 === 4'b1000) got3 = 1'b1;
      end
    end
    total++;
    if (got3 !== 1'b1) begin
      bad++;
      $display("FAIL late_grant: got seen=%b, want input 3 within 4", seen);
    end
    total++;
    if (dup !== 1'b0) begin
      bad++;
      $display("FAIL late_dup: got dup=%b, want 0", dup);
    end
  endtask

  initial begin
    d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    d3 = {8'hC2, 8'hC1, 8'hC0};
    test_reset();
    test_contention();
    test_backpressure();
    test_sparse_wrap();
    test_async_reset();
    test_late_arrival();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
